// File: rtl/alu_share_arbiter.sv
// Two-requester arbiter in front of one shared 32-bit ALU.
// Each operation takes IDLE -> EXEC -> RESULT and is handed over on res_valid/res_ready.
module alu_share_arbiter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [2:0]       req0_op,
    input  logic [31:0]      req0_a,
    input  logic [31:0]      req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [2:0]       req1_op,
    input  logic [31:0]      req1_a,
    input  logic [31:0]      req1_b,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_id,
    output logic [31:0]      res_data,
    output logic             res_zero,
    output logic             res_err,
    output logic [CNT_W-1:0] op_count
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXEC   = 2'd1,
        RESULT = 2'd2
    } state_t;

    state_t state, state_nxt;
    logic   prio;
    logic   grant0, grant1;
    logic   take;

    logic [2:0]          op_p0;
    logic signed [31:0]  a_p0;
    logic signed [31:0]  b_p0;
    logic                id_p0;
    logic [32:0]         alu_p0;

    // Returns {err, data}; unsupported codes yield zero data with err set.
    function automatic logic [32:0] alu_eval(input logic [2:0] op,
                                             input logic signed [31:0] a,
                                             input logic signed [31:0] b);
        logic [32:0] r;
        r = '0;
        case (op)
            3'b000:  r = {1'b0, a & b};
            3'b001:  r = {1'b0, a | b};
            3'b010:  r = {1'b0, a + b};
            3'b110:  r = {1'b0, a - b};
            3'b111:  r = {1'b0, 31'd0, (a < b)};
            default: r = {1'b1, 32'd0};
        endcase
        return r;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        grant0    = 1'b0;
        grant1    = 1'b0;
        case (state)
            IDLE: begin
                grant0 = req0_valid && (!req1_valid || !prio);
                grant1 = req1_valid && (!req0_valid ||  prio);
                if (grant0 || grant1) state_nxt = EXEC;
            end
            EXEC:    state_nxt = RESULT;
            RESULT:  if (res_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign res_valid  = (state == RESULT);
    assign take       = (state == RESULT) && res_ready;

    // Stage p0: operands captured on accept
    always_ff @(posedge clk) begin
        if (grant0 || grant1) begin
            op_p0 <= grant1 ? req1_op : req0_op;
            a_p0  <= grant1 ? req1_a  : req0_a;
            b_p0  <= grant1 ? req1_b  : req0_b;
            id_p0 <= grant1;
        end
    end

    assign alu_p0 = alu_eval(op_p0, a_p0, b_p0);

    // Stage p1: result registers, held for the whole RESULT phase
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            res_data <= '0;
            res_zero <= 1'b0;
            res_err  <= 1'b0;
            res_id   <= 1'b0;
            prio     <= 1'b0;
            op_count <= '0;
        end else begin
            if (state == EXEC) begin
                res_data <= alu_p0[31:0];
                res_err  <= alu_p0[32];
                res_zero <= (alu_p0[31:0] == 32'd0);
                res_id   <= id_p0;
            end
            if (take) begin
                op_count <= sat_inc(op_count);
                prio     <= ~res_id;
            end
        end
    end

endmodule
